// File: rtl/regfile_sb_pkg.sv
// rtl/regfile_sb_pkg.sv - shared defaults and constants for the risc16 register file
package regfile_sb_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 3;
  localparam int REG_ZERO   = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - busy-bit scoreboard with pending count and hazard flags
module regfile_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_dest,
  input  logic [ADDR_W-1:0] rd_addr_1,
  input  logic [ADDR_W-1:0] rd_addr_2,
  output logic              rd_busy_1,
  output logic              rd_busy_2,
  output logic              issue_waw,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int NREGS = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] R0 = ADDR_W'(REG_ZERO);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic             set_eff;
  logic             clr_eff;
  logic             inc;
  logic             dec;

  // A same-cycle issue to the register being written back keeps it busy.
  always_comb begin
    set_eff  = issue_en && !(ZERO_REG != 0 && issue_dest == R0);
    clr_eff  = wr_en && !(ZERO_REG != 0 && wr_addr == R0)
               && !(set_eff && issue_dest == wr_addr);
    inc      = set_eff && !busy[issue_dest];
    dec      = clr_eff && busy[wr_addr];
    busy_nxt = busy;
    if (clr_eff) busy_nxt[wr_addr] = 1'b0;
    if (set_eff) busy_nxt[issue_dest] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      pend_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      pend_cnt <= pend_cnt + CNT_W'(inc) - CNT_W'(dec);
    end
  end

  assign rd_busy_1 = busy[rd_addr_1] && !(wr_en && wr_addr == rd_addr_1);
  assign rd_busy_2 = busy[rd_addr_2] && !(wr_en && wr_addr == rd_addr_2);
  assign issue_waw = busy[issue_dest] && !(wr_en && wr_addr == issue_dest);

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - two-read one-write register file with bypass and busy scoreboard
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int RD_REG   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_dest,
  input  logic [ADDR_W-1:0] rd_addr_1,
  output logic [DATA_W-1:0] rd_data_1,
  output logic              rd_busy_1,
  input  logic [ADDR_W-1:0] rd_addr_2,
  output logic [DATA_W-1:0] rd_data_2,
  output logic              rd_busy_2,
  output logic              issue_waw,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int NREGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] R0 = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs [NREGS];
  logic              wr_eff;
  logic [DATA_W-1:0] v1;
  logic [DATA_W-1:0] v2;

  assign wr_eff = wr_en && !(ZERO_REG != 0 && wr_addr == R0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_eff) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    v1 = regs[rd_addr_1];
    if (BYPASS != 0 && wr_en && wr_addr == rd_addr_1) v1 = wr_data;
    if (ZERO_REG != 0 && rd_addr_1 == R0) v1 = '0;
    v2 = regs[rd_addr_2];
    if (BYPASS != 0 && wr_en && wr_addr == rd_addr_2) v2 = wr_data;
    if (ZERO_REG != 0 && rd_addr_2 == R0) v2 = '0;
  end

  generate
    if (RD_REG != 0) begin : g_rd_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_data_1 <= '0;
          rd_data_2 <= '0;
        end else begin
          rd_data_1 <= v1;
          rd_data_2 <= v2;
        end
      end
    end else begin : g_rd_comb
      assign rd_data_1 = v1;
      assign rd_data_2 = v2;
    end
  endgenerate

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .issue_en   (issue_en),
    .issue_dest (issue_dest),
    .rd_addr_1  (rd_addr_1),
    .rd_addr_2  (rd_addr_2),
    .rd_busy_1  (rd_busy_1),
    .rd_busy_2  (rd_busy_2),
    .issue_waw  (issue_waw),
    .pend_cnt   (pend_cnt)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - table-driven bench for regfile_sb in default, no-bypass and registered-read builds
module tb_regfile_sb;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        issue_en;
  logic [2:0]  issue_dest;
  logic [2:0]  rd_addr_1;
  logic [2:0]  rd_addr_2;

  logic [15:0] d_rd1, d_rd2, nb_rd1, nb_rd2, rr_rd1, rr_rd2;
  logic        d_b1, d_b2, d_waw, nb_b1, nb_b2, nb_waw, rr_b1, rr_b2, rr_waw;
  logic [3:0]  d_cnt, nb_cnt, rr_cnt;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q [$];

  regfile_sb dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_dest(issue_dest),
    .rd_addr_1(rd_addr_1), .rd_data_1(d_rd1), .rd_busy_1(d_b1),
    .rd_addr_2(rd_addr_2), .rd_data_2(d_rd2), .rd_busy_2(d_b2),
    .issue_waw(d_waw), .pend_cnt(d_cnt)
  );

  regfile_sb #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_dest(issue_dest),
    .rd_addr_1(rd_addr_1), .rd_data_1(nb_rd1), .rd_busy_1(nb_b1),
    .rd_addr_2(rd_addr_2), .rd_data_2(nb_rd2), .rd_busy_2(nb_b2),
    .issue_waw(nb_waw), .pend_cnt(nb_cnt)
  );

  regfile_sb #(.RD_REG(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_dest(issue_dest),
    .rd_addr_1(rd_addr_1), .rd_data_1(rr_rd1), .rd_busy_1(rr_b1),
    .rd_addr_2(rd_addr_2), .rd_data_2(rr_rd2), .rd_busy_2(rr_b2),
    .issue_waw(rr_waw), .pend_cnt(rr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic        ie;
    logic [2:0]  id;
    logic [2:0]  ra1;
    logic [2:0]  ra2;
    logic [15:0] e_rd1;
    logic [15:0] e_nb1;
    logic        e_b1;
    logic [15:0] e_rd2;
    logic        e_b2;
    logic        e_waw;
    logic [3:0]  e_cnt;
  } vec_t;

  localparam int NV = 16;
  vec_t vec [NV];

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                       input logic ie, input logic [2:0] id, input logic [2:0] ra1, input logic [2:0] ra2);
    wr_en = we; wr_addr = wa; wr_data = wd;
    issue_en = ie; issue_dest = id;
    rd_addr_1 = ra1; rd_addr_2 = ra2;
  endtask

  initial begin
    //            we   wa    wd        ie   id    ra1   ra2   e_rd1     e_nb1     b1    e_rd2     b2    waw   cnt
    vec[0]  = '{1'b0,3'd0,16'h0000,1'b0,3'd0,3'd0,3'd7,16'h0000,16'h0000,1'b0,16'h0000,1'b0,1'b0,4'd0};
    vec[1]  = '{1'b1,3'd3,16'h1234,1'b0,3'd0,3'd3,3'd3,16'h1234,16'h0000,1'b0,16'h1234,1'b0,1'b0,4'd0};
    vec[2]  = '{1'b0,3'd0,16'h0000,1'b1,3'd5,3'd5,3'd3,16'h0000,16'h0000,1'b0,16'h1234,1'b0,1'b0,4'd0};
    vec[3]  = '{1'b0,3'd0,16'h0000,1'b0,3'd5,3'd5,3'd3,16'h0000,16'h0000,1'b1,16'h1234,1'b0,1'b1,4'd1};
    vec[4]  = '{1'b1,3'd5,16'hBEEF,1'b0,3'd5,3'd5,3'd5,16'hBEEF,16'h0000,1'b0,16'hBEEF,1'b0,1'b0,4'd1};
    vec[5]  = '{1'b0,3'd0,16'h0000,1'b1,3'd2,3'd2,3'd5,16'h0000,16'h0000,1'b0,16'hBEEF,1'b0,1'b0,4'd0};
    vec[6]  = '{1'b1,3'd2,16'h5A5A,1'b1,3'd2,3'd2,3'd5,16'h5A5A,16'h0000,1'b0,16'hBEEF,1'b0,1'b0,4'd1};
    vec[7]  = '{1'b0,3'd0,16'h0000,1'b0,3'd2,3'd2,3'd0,16'h5A5A,16'h5A5A,1'b1,16'h0000,1'b0,1'b1,4'd1};
    vec[8]  = '{1'b1,3'd0,16'hFFFF,1'b1,3'd0,3'd0,3'd2,16'h0000,16'h0000,1'b0,16'h5A5A,1'b1,1'b0,4'd1};
    vec[9]  = '{1'b0,3'd0,16'h0000,1'b0,3'd0,3'd0,3'd0,16'h0000,16'h0000,1'b0,16'h0000,1'b0,1'b0,4'd1};
    vec[10] = '{1'b1,3'd2,16'h0011,1'b1,3'd4,3'd4,3'd2,16'h0000,16'h0000,1'b0,16'h0011,1'b0,1'b0,4'd1};
    vec[11] = '{1'b1,3'd4,16'h00AA,1'b0,3'd4,3'd4,3'd2,16'h00AA,16'h0000,1'b0,16'h0011,1'b0,1'b0,4'd1};
    vec[12] = '{1'b0,3'd0,16'h0000,1'b0,3'd0,3'd4,3'd7,16'h00AA,16'h00AA,1'b0,16'h0000,1'b0,1'b0,4'd0};
    vec[13] = '{1'b0,3'd0,16'h0000,1'b1,3'd6,3'd6,3'd7,16'h0000,16'h0000,1'b0,16'h0000,1'b0,1'b0,4'd0};
    vec[14] = '{1'b0,3'd0,16'h0000,1'b1,3'd6,3'd6,3'd7,16'h0000,16'h0000,1'b1,16'h0000,1'b0,1'b1,4'd1};
    vec[15] = '{1'b0,3'd0,16'h0000,1'b0,3'd6,3'd6,3'd7,16'h0000,16'h0000,1'b1,16'h0000,1'b0,1'b1,4'd1};

    rst_n = 1'b0;
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 3'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int a = 0; a < 8; a++) begin
      drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'(a), 3'(7 - a));
      #1;
      chk("rst_rd1", a, d_rd1, 16'h0);
      chk("rst_rd2", a, d_rd2, 16'h0);
      chk("rst_busy1", a, 16'(d_b1), 16'h0);
      chk("rst_busy2", a, 16'(d_b2), 16'h0);
      chk("rst_cnt", a, 16'(d_cnt), 16'h0);
      chk("rst_rr_rd1", a, rr_rd1, 16'h0);
      @(negedge clk);
    end

    for (int i = 0; i < NV; i++) begin
      drive(vec[i].we, vec[i].wa, vec[i].wd, vec[i].ie, vec[i].id, vec[i].ra1, vec[i].ra2);
      #1;
      chk("rd1", i, d_rd1, vec[i].e_rd1);
      chk("nb_rd1", i, nb_rd1, vec[i].e_nb1);
      chk("busy1", i, 16'(d_b1), 16'(vec[i].e_b1));
      chk("rd2", i, d_rd2, vec[i].e_rd2);
      chk("busy2", i, 16'(d_b2), 16'(vec[i].e_b2));
      chk("waw", i, 16'(d_waw), 16'(vec[i].e_waw));
      chk("cnt", i, 16'(d_cnt), 16'(vec[i].e_cnt));
      chk("rr_busy1", i, 16'(rr_b1), 16'(vec[i].e_b1));
      exp_q.push_back(vec[i].e_rd1);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        chk("rr_queue_empty", i, 16'h0, 16'h1);
      end else begin
        chk("rr_rd1", i, rr_rd1, exp_q.pop_front());
      end
      @(negedge clk);
    end

    // Saturate the scoreboard: every register except r0 becomes busy.
    for (int a = 1; a < 8; a++) begin
      drive(1'b0, 3'd0, 16'h0, 1'b1, 3'(a), 3'd4, 3'd7);
      @(negedge clk);
    end
    drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 3'd4, 3'd7);
    @(negedge clk);
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd4, 3'd7);
    #1;
    chk("full_cnt", 0, 16'(d_cnt), 16'd7);
    chk("full_busy1", 0, 16'(d_b1), 16'h1);
    chk("full_rr_rd1", 0, rr_rd1, 16'h00AA);
    chk("full_rd1", 0, d_rd1, 16'h00AA);

    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_rr_rd1", 0, rr_rd1, 16'h0);
    chk("midrst_rd1", 0, d_rd1, 16'h0);
    chk("midrst_cnt", 0, 16'(d_cnt), 16'h0);
    chk("midrst_busy1", 0, 16'(d_b1), 16'h0);

    drive(1'b1, 3'd4, 16'h1234, 1'b1, 3'd4, 3'd4, 3'd7);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd4, 3'd7);
    #1;
    chk("rstdrop_rd1", 0, d_rd1, 16'h0);
    chk("rstdrop_busy1", 0, 16'(d_b1), 16'h0);
    chk("rstdrop_cnt", 0, 16'(d_cnt), 16'h0);
    @(posedge clk);
    #1;
    chk("rstdrop_rr_rd1", 0, rr_rd1, 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
